// File: rtl/wishbone_bus_arbiter_if.sv
// Shared-bus bundle between two Wishbone masters, the arbiter and one slave.
// Master 0 (ibus) occupies the low slice of every packed vector and master 1 (dbus) the high slice.
interface wishbone_bus_arbiter_if #(
   parameter int unsigned ADR_WIDTH = 30,
   parameter int unsigned DAT_WIDTH = 32
);
   localparam int unsigned SEL_W = DAT_WIDTH / 8;

   logic [1:0]             m_cyc;
   logic [1:0]             m_stb;
   logic [1:0]             m_we;
   logic [2*ADR_WIDTH-1:0] m_adr;
   logic [2*DAT_WIDTH-1:0] m_dat_mosi;
   logic [2*SEL_W-1:0]     m_sel;
   logic [DAT_WIDTH-1:0]   m_dat_miso;
   logic [1:0]             m_ack;
   logic [1:0]             m_err;
   logic                   s_cyc;
   logic                   s_stb;
   logic                   s_we;
   logic [ADR_WIDTH-1:0]   s_adr;
   logic [DAT_WIDTH-1:0]   s_dat_mosi;
   logic [SEL_W-1:0]       s_sel;
   logic [DAT_WIDTH-1:0]   s_dat_miso;
   logic                   s_ack;
   logic                   s_err;
   logic [1:0]             grant;

   // Arbiter view: it is the master of the shared slave port.
   modport master (
      input  m_cyc, m_stb, m_we, m_adr, m_dat_mosi, m_sel, s_dat_miso, s_ack, s_err,
      output m_dat_miso, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_mosi, s_sel, grant
   );

   // Environment view: the requesting masters and the shared slave.
   modport slave (
      output m_cyc, m_stb, m_we, m_adr, m_dat_mosi, m_sel, s_dat_miso, s_ack, s_err,
      input  m_dat_miso, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_mosi, s_sel, grant
   );
endinterface

// File: rtl/wishbone_bus_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with a grant held for the whole CYC,
// round-robin tie break and a watchdog that turns an unanswered strobe into ERR.
module wishbone_bus_arbiter #(
   parameter int unsigned ADR_WIDTH      = 30,
   parameter int unsigned DAT_WIDTH      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                   clk,
   input logic                   reset,
   wishbone_bus_arbiter_if.master bus
);
   localparam int unsigned SEL_W = DAT_WIDTH / 8;
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0] WD_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);

   // State encoding doubles as the one-hot grant.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OWN_I = 2'b01,
      OWN_D = 2'b10
   } state_t;

   state_t               r_state;
   state_t               w_next;
   state_t               w_arb;
   logic                 r_last_d;
   logic [WD_W-1:0]      r_wd_cnt;

   logic                 w_cyc;
   logic                 w_stb_raw;
   logic                 w_we;
   logic [ADR_WIDTH-1:0] w_adr;
   logic [DAT_WIDTH-1:0] w_dat;
   logic [SEL_W-1:0]     w_sel;
   logic                 w_silent;
   logic                 w_wd_fire;

   // Arbitration over the current requests; a tie goes to the master that did not own last.
   always_comb begin
      w_arb = IDLE;
      if (bus.m_cyc[0] && bus.m_cyc[1]) w_arb = r_last_d ? OWN_I : OWN_D;
      else if (bus.m_cyc[0])            w_arb = OWN_I;
      else if (bus.m_cyc[1])            w_arb = OWN_D;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_arb;
         OWN_I:   if (!bus.m_cyc[0]) w_next = w_arb;
         OWN_D:   if (!bus.m_cyc[1]) w_next = w_arb;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_last_d <= 1'b1;
      end else begin
         r_state <= w_next;
         if (w_next == OWN_I)      r_last_d <= 1'b0;
         else if (w_next == OWN_D) r_last_d <= 1'b1;
      end
   end

   // Owner-to-slave mux; everything idles at zero with no owner.
   always_comb begin
      w_cyc     = 1'b0;
      w_stb_raw = 1'b0;
      w_we      = 1'b0;
      w_adr     = '0;
      w_dat     = '0;
      w_sel     = '0;
      if (r_state == OWN_I) begin
         w_cyc     = bus.m_cyc[0];
         w_stb_raw = bus.m_stb[0];
         w_we      = bus.m_we[0];
         w_adr     = bus.m_adr[0 +: ADR_WIDTH];
         w_dat     = bus.m_dat_mosi[0 +: DAT_WIDTH];
         w_sel     = bus.m_sel[0 +: SEL_W];
      end else if (r_state == OWN_D) begin
         w_cyc     = bus.m_cyc[1];
         w_stb_raw = bus.m_stb[1];
         w_we      = bus.m_we[1];
         w_adr     = bus.m_adr[ADR_WIDTH +: ADR_WIDTH];
         w_dat     = bus.m_dat_mosi[DAT_WIDTH +: DAT_WIDTH];
         w_sel     = bus.m_sel[SEL_W +: SEL_W];
      end
   end

   assign w_silent  = w_cyc & w_stb_raw & ~bus.s_ack & ~bus.s_err;
   assign w_wd_fire = (TIMEOUT_CYCLES != 0) && w_silent && (r_wd_cnt == WD_LAST);

   // Saturating watchdog; a fire, any answer, STB low or a grant change restarts it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                         r_wd_cnt <= '0;
      else if (!w_silent || w_wd_fire || w_next != r_state) r_wd_cnt <= '0;
      else if (r_wd_cnt != '1)                           r_wd_cnt <= r_wd_cnt + WD_W'(1);
   end

   assign bus.s_cyc      = w_cyc;
   assign bus.s_stb      = w_stb_raw & ~w_wd_fire;
   assign bus.s_we       = w_we;
   assign bus.s_adr      = w_adr;
   assign bus.s_dat_mosi = w_dat;
   assign bus.s_sel      = w_sel;
   assign bus.grant      = r_state;
   assign bus.m_dat_miso = (r_state != IDLE) ? bus.s_dat_miso : '0;
   assign bus.m_ack      = r_state & {2{bus.s_ack}};
   assign bus.m_err      = r_state & {2{bus.s_err | w_wd_fire}};
endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Directed bench for wishbone_bus_arbiter: arbitration, hold, muxing, watchdog and async reset.
module tb_wishbone_bus_arbiter;
   localparam int unsigned AW = 30;
   localparam int unsigned DW = 32;

   logic clk;
   logic reset;
   int   n_err;
   int   n_checks;

   wishbone_bus_arbiter_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) bus ();

   wishbone_bus_arbiter #(
      .ADR_WIDTH      (AW),
      .DAT_WIDTH      (DW),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_err = 0;
      n_checks = 0;
      reset = 1'b1;
      bus.m_cyc = 2'b11;
      bus.m_stb = 2'b11;
      bus.m_we = 2'b11;
      bus.m_adr = {30'h3ABC_DEF0, 30'h0123_4567};
      bus.m_dat_mosi = {32'hCAFE_F00D, 32'h1234_5678};
      bus.m_sel = 8'hA5;
      bus.s_dat_miso = 32'h5555_AAAA;
      bus.s_ack = 1'b1;
      bus.s_err = 1'b1;
      #2;
      // outputs are all zero while reset is held
      chk("rst_grant", 64'(bus.grant), 64'h0);
      chk("rst_s_cyc", 64'(bus.s_cyc), 64'h0);
      chk("rst_s_stb", 64'(bus.s_stb), 64'h0);
      chk("rst_m_ack", 64'(bus.m_ack), 64'h0);
      chk("rst_m_err", 64'(bus.m_err), 64'h0);
      chk("rst_miso", 64'(bus.m_dat_miso), 64'h0);
      tick();
      tick();
      reset = 1'b0;
      bus.m_cyc = 2'b00;
      bus.m_stb = 2'b00;
      bus.m_we = 2'b00;
      tick();
      // idle: slave answers are ignored
      chk("idle_grant", 64'(bus.grant), 64'h0);
      chk("idle_s_cyc", 64'(bus.s_cyc), 64'h0);
      chk("idle_s_adr", 64'(bus.s_adr), 64'h0);
      chk("idle_s_dat", 64'(bus.s_dat_mosi), 64'h0);
      chk("idle_m_ack", 64'(bus.m_ack), 64'h0);
      chk("idle_m_err", 64'(bus.m_err), 64'h0);
      bus.s_ack = 1'b0;
      bus.s_err = 1'b0;

      // Test 1: ibus request appears on the slave one cycle later
      bus.m_cyc = 2'b01;
      bus.m_stb = 2'b01;
      #1;
      chk("t1_latency_grant", 64'(bus.grant), 64'h0);
      chk("t1_latency_s_cyc", 64'(bus.s_cyc), 64'h0);
      tick();
      chk("t1_grant", 64'(bus.grant), 64'h1);
      chk("t1_s_cyc", 64'(bus.s_cyc), 64'h1);
      chk("t1_s_stb", 64'(bus.s_stb), 64'h1);
      chk("t1_s_adr", 64'(bus.s_adr), 64'h0123_4567);
      chk("t1_s_sel", 64'(bus.s_sel), 64'h5);
      chk("t1_s_dat", 64'(bus.s_dat_mosi), 64'h1234_5678);
      // Test 4: read data and ack reach the owner only
      bus.s_ack = 1'b1;
      bus.s_dat_miso = 32'hDEAD_BEEF;
      #1;
      chk("t4_m_ack", 64'(bus.m_ack), 64'h1);
      chk("t4_miso", 64'(bus.m_dat_miso), 64'hDEAD_BEEF);
      tick();
      bus.s_ack = 1'b0;
      bus.m_cyc = 2'b00;
      bus.m_stb = 2'b00;
      tick();
      chk("t1_release", 64'(bus.grant), 64'h0);

      // Test 2: first tie after reset goes to ibus, then dbus without a dead cycle
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.m_cyc = 2'b11;
      tick();
      chk("t2_tie1", 64'(bus.grant), 64'h1);
      bus.m_cyc = 2'b10;
      #1;
      chk("t2_hold_until_edge", 64'(bus.grant), 64'h1);
      tick();
      chk("t2_handover", 64'(bus.grant), 64'h2);
      bus.m_cyc = 2'b11;
      tick();
      chk("t2_dbus_holds", 64'(bus.grant), 64'h2);
      bus.m_cyc = 2'b00;
      tick();
      chk("t2_idle", 64'(bus.grant), 64'h0);
      bus.m_cyc = 2'b11;
      tick();
      chk("t2_tie2", 64'(bus.grant), 64'h1);

      // Test 3: dbus holds CYC across three beats while ibus waits
      bus.m_cyc = 2'b00;
      tick();
      bus.m_cyc = 2'b10;
      tick();
      chk("t3_grant_d", 64'(bus.grant), 64'h2);
      bus.m_cyc = 2'b11;
      bus.m_stb = 2'b10;
      bus.m_we = 2'b10;
      bus.s_ack = 1'b1;
      for (int b = 0; b < 3; b++) begin
         #1;
         chk("t3_beat_grant", 64'(bus.grant), 64'h2);
         chk("t3_beat_ack", 64'(bus.m_ack), 64'h2);
         chk("t3_beat_adr", 64'(bus.s_adr), 64'h3ABC_DEF0);
         chk("t3_beat_we", 64'(bus.s_we), 64'h1);
         chk("t3_beat_miso", 64'(bus.m_dat_miso), 64'hDEAD_BEEF);
         tick();
      end
      bus.m_stb = 2'b00;
      bus.s_ack = 1'b0;
      #1;
      chk("t3_stb_low_hold", 64'(bus.grant), 64'h2);
      tick();
      bus.m_cyc = 2'b01;
      #1;
      chk("t3_drop_same_cycle", 64'(bus.grant), 64'h2);
      chk("t3_ibus_no_ack", 64'(bus.m_ack), 64'h0);
      tick();
      chk("t3_ibus_granted", 64'(bus.grant), 64'h1);

      // Test 5: watchdog fires on the fourth silent strobe cycle
      bus.m_stb = 2'b01;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t5_wait_stb", 64'(bus.s_stb), 64'h1);
         chk("t5_wait_err", 64'(bus.m_err), 64'h0);
         tick();
      end
      #1;
      chk("t5_fire_stb", 64'(bus.s_stb), 64'h0);
      chk("t5_fire_err", 64'(bus.m_err), 64'h1);
      chk("t5_fire_cyc", 64'(bus.s_cyc), 64'h1);
      tick();
      chk("t5_pulse_end_err", 64'(bus.m_err), 64'h0);
      chk("t5_pulse_end_stb", 64'(bus.s_stb), 64'h1);
      tick();
      tick();
      tick();
      bus.s_ack = 1'b1;
      #1;
      chk("t5_ack_wins_ack", 64'(bus.m_ack), 64'h1);
      chk("t5_ack_wins_err", 64'(bus.m_err), 64'h0);
      chk("t5_ack_wins_stb", 64'(bus.s_stb), 64'h1);
      tick();
      bus.s_ack = 1'b0;
      bus.s_err = 1'b1;
      #1;
      chk("t5_slave_err", 64'(bus.m_err), 64'h1);
      tick();
      bus.s_err = 1'b0;

      // Test 6: async reset mid-transfer, then pending ibus wins
      bus.m_cyc = 2'b00;
      bus.m_stb = 2'b00;
      tick();
      bus.m_cyc = 2'b10;
      bus.m_stb = 2'b10;
      tick();
      chk("t6_grant_d", 64'(bus.grant), 64'h2);
      chk("t6_s_cyc_on", 64'(bus.s_cyc), 64'h1);
      bus.m_cyc = 2'b11;
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_grant", 64'(bus.grant), 64'h0);
      chk("t6_async_s_cyc", 64'(bus.s_cyc), 64'h0);
      chk("t6_async_s_stb", 64'(bus.s_stb), 64'h0);
      tick();
      reset = 1'b0;
      #1;
      chk("t6_post_rst_idle", 64'(bus.grant), 64'h0);
      tick();
      chk("t6_ibus_first", 64'(bus.grant), 64'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/wishbone_bus_arbiter.md
Name: wishbone_bus_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- It lets the CPU instruction bus (master 0, ibus) and data bus (master 1, dbus) share a single slave port, for example a unified RAM or peripheral interconnect.
- The grant is registered and held for the whole CYC of the owning master.
- On a tie, arbitration is round-robin.
- A bus watchdog terminates transfers the slave never answers, by raising ERR to the owning master.

Parameters:
- ADR_WIDTH, 30, word address width per master.
- DAT_WIDTH, 32, data width. SEL width is DAT_WIDTH/8.
- TIMEOUT_CYCLES, 1024, number of unanswered strobe cycles before a watchdog ERR. 0 disables the watchdog.

Ports:
Vectors below are packed with master 0 (ibus) in the low slice and master 1 (dbus) in the high slice.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_cyc  in  2  master CYC.
- m_stb  in  2  master STB.
- m_we  in  2  master WE.
- m_adr  in  2*ADR_WIDTH  master addresses.
- m_dat_mosi  in  2*DAT_WIDTH  master write data.
- m_sel  in  2*DAT_WIDTH/8  master byte selects.
- m_dat_miso  out  DAT_WIDTH  read data, broadcast to both masters.
- m_ack  out  2  ACK per master.
- m_err  out  2  ERR per master.
- s_cyc  out  1  slave CYC.
- s_stb  out  1  slave STB.
- s_we  out  1  slave WE.
- s_adr  out  ADR_WIDTH  slave address.
- s_dat_mosi  out  DAT_WIDTH  slave write data.
- s_sel  out  DAT_WIDTH/8  slave byte select.
- s_dat_miso  in  DAT_WIDTH  slave read data.
- s_ack  in  1  slave ACK.
- s_err  in  1  slave ERR.
- grant  out  2  one-hot current owner; 00 means idle.

Behaviour:

Reset:
- While reset is high: state IDLE, grant=00, last_owner=dbus, watchdog count=0.
- Every output is 0 while reset is high.
- Reset mid-transfer drops s_cyc and s_stb immediately, asynchronously. The slave must tolerate this abort.

State machine:
- States are IDLE, OWN_I and OWN_D. grant is the registered one-hot encoding of the state.
- IDLE transitions:
  - Only m_cyc[0] high: go to OWN_I.
  - Only m_cyc[1] high: go to OWN_D.
  - Both high: grant the master that is not last_owner. After reset, ibus wins the first tie.
- OWN_x holds while m_cyc[x] is high, regardless of STB. Multi-beat and read-modify-write sequences are therefore atomic.
- When the owner deasserts m_cyc, the next state is the arbitration result over the current requests. A pending other master is granted directly at that edge, with no dead cycle. If there is no request, the next state is IDLE.
- last_owner is updated on every grant.

Latency:
- A request raised in IDLE at cycle N appears on the slave port at N+1. There is one cycle of arbitration latency.
- While granted, the path from master to slave is purely combinational (mux on grant). There is zero added latency per beat.

Muxing:
- s_cyc = m_cyc[owner]. s_stb = m_stb[owner] & ~wd_fire.
- s_we, s_adr, s_dat_mosi and s_sel come from the owner.
- When idle, all slave outputs are 0.
- m_ack[owner] = s_ack. m_err[owner] = s_err | wd_fire.
- The non-owner always sees ack=0 and err=0.
- s_ack or s_err received while idle is ignored.

Watchdog:
- Counts clocks while s_cyc & s_stb & ~s_ack & ~s_err.
- Clears on ack, on err, on STB low, and on a grant change.
- wd_fire is asserted combinationally when count == TIMEOUT_CYCLES-1 and the slave is still silent.
- In that cycle s_stb is forced low and m_err[owner] pulses for exactly 1 cycle. The counter clears at the next edge.
- Counter width is clog2(TIMEOUT_CYCLES)+1. It saturates and never wraps.
- With TIMEOUT_CYCLES=0, wd_fire is constant 0.

Simultaneous events:
- s_ack and wd_fire in the same cycle: ack wins. wd_fire is suppressed because the slave answered.
- Owner drops CYC in the same cycle the other master raises it: the handover happens at the next edge.

Test Plan:
1. Reset release with both m_cyc=00 -> grant=00 and every slave output 0. Then m_cyc=01 with stb at cycle 5 -> grant=01 and s_cyc=s_stb=1 at cycle 6, s_adr equals m_adr[29:0].
2. Both masters raise CYC in the same cycle after reset -> ibus is granted. When ibus drops CYC, dbus is granted at the next edge. On the next tie, ibus wins.
3. dbus owns the bus and holds CYC across 3 STB beats while ibus requests -> grant stays 10 until dbus CYC falls. Ibus m_ack stays 0 throughout.
4. Slave returns s_ack with s_dat_miso=0xDEADBEEF -> owner m_ack=1 in the same cycle, m_dat_miso=0xDEADBEEF, non-owner ack=0.
5. TIMEOUT_CYCLES=4, slave silent -> m_err[owner] pulses for 1 cycle on the 4th strobe cycle with s_stb=0 in that cycle. A later s_ack arriving in the same cycle as a would-be timeout -> ack only, no err.
6. Assert reset mid-transfer while dbus is granted -> grant=00 and s_cyc=0 before the next clock edge. After release, a pending ibus request is granted first.
